tmax_pattern_checker: RTL and testbench

- Synthesizable, parametrised successor to the non-scan TetraMAX capture testbench flow.
- Stores up to DEPTH ATPG patterns, each made of a PI vector, an expected PO vector and a measure mask.
- Applies each pattern to a DUT, waits a programmable settle time, then samples and compares masked outputs.
- Reports per-pattern failures and a saturating fail count, for on-chip/FPGA replay of basic_scan-less patterns.

---
 rtl/tmax_pattern_checker.sv | 147 ++++++++++++++
 tb/tb_tmax_pattern_checker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmax_pattern_checker.sv
// Replays stored ATPG capture patterns (PI force, settle, masked PO measure)
// and reports per-pattern failures plus a saturating fail count.
module tmax_pattern_checker #(
  parameter int NINPUTS     = 5,
  parameter int NOUTPUTS    = 2,
  parameter int DEPTH       = 16,
  parameter int CAPTURE_DLY = 4,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [NINPUTS-1:0]       ld_pi,
  input  logic [NOUTPUTS-1:0]      ld_xpct,
  input  logic [NOUTPUTS-1:0]      ld_mask,
  input  logic                     start,
  input  logic                     stop_on_fail,
  output logic [NINPUTS-1:0]       pi_out,
  input  logic [NOUTPUTS-1:0]      po_in,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail_valid,
  output logic [$clog2(DEPTH)-1:0] fail_pattern,
  output logic [NOUTPUTS-1:0]      fail_bits,
  output logic [CNT_W-1:0]         nofails,
  output logic [$clog2(DEPTH):0]   npatterns
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CAPTURE_DLY > 1) ? $clog2(CAPTURE_DLY) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FORCE   = 3'd1,
    WAIT    = 3'd2,
    MEASURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t state, next_state;

  logic [NINPUTS-1:0]  pi_mem   [DEPTH];
  logic [NOUTPUTS-1:0] xpct_mem [DEPTH];
  logic [NOUTPUTS-1:0] mask_mem [DEPTH];

  logic [AW-1:0]       ptr;
  logic [CW-1:0]       wait_cnt;
  logic [NOUTPUTS-1:0] mism;
  logic                ld_fire;
  logic                last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    ld_ready   = ((state == IDLE) || (state == DONE)) && !start && !clear &&
                 (npatterns < (AW+1)'(DEPTH));
    ld_fire    = ld_valid && ld_ready;
    mism       = (po_in ^ xpct_mem[ptr]) & mask_mem[ptr];
    last       = ({1'b0, ptr} == (npatterns - (AW+1)'(1)));
    case (state)
      IDLE, DONE: begin
        if (start) next_state = (npatterns == '0) ? DONE : FORCE;
      end
      FORCE:   next_state = WAIT;
      WAIT:    if (wait_cnt == '0) next_state = MEASURE;
      MEASURE: begin
        if (last || (stop_on_fail && (mism != '0))) next_state = DONE;
        else                                        next_state = FORCE;
      end
      default: next_state = IDLE;
    endcase
    if (clear) next_state = IDLE;
  end

  assign busy = (state == FORCE) || (state == WAIT) || (state == MEASURE);
  assign done = (state == DONE);
  assign pass = done && (nofails == '0);

  // Pattern storage carries no reset; npatterns alone defines what is valid.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      pi_mem[npatterns[AW-1:0]]   <= ld_pi;
      xpct_mem[npatterns[AW-1:0]] <= ld_xpct;
      mask_mem[npatterns[AW-1:0]] <= ld_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      npatterns    <= '0;
      nofails      <= '0;
      pi_out       <= '0;
      fail_valid   <= 1'b0;
      fail_pattern <= '0;
      fail_bits    <= '0;
      ptr          <= '0;
      wait_cnt     <= '0;
    end else if (clear) begin
      npatterns    <= '0;
      nofails      <= '0;
      pi_out       <= '0;
      fail_valid   <= 1'b0;
      fail_pattern <= '0;
      fail_bits    <= '0;
      ptr          <= '0;
      wait_cnt     <= '0;
    end else begin
      fail_valid <= 1'b0;
      if (ld_fire) npatterns <= npatterns + (AW+1)'(1);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            nofails      <= '0;
            ptr          <= '0;
            fail_pattern <= '0;
            fail_bits    <= '0;
          end
        end
        FORCE: begin
          pi_out   <= pi_mem[ptr];
          wait_cnt <= CW'(CAPTURE_DLY - 1);
        end
        WAIT: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - CW'(1);
        end
        MEASURE: begin
          if (mism != '0) begin
            fail_valid   <= 1'b1;
            fail_pattern <= ptr;
            fail_bits    <= mism;
            if (nofails != {CNT_W{1'b1}}) nofails <= nofails + CNT_W'(1);
          end
          if (next_state == FORCE) ptr <= ptr + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tmax_pattern_checker.sv
// Directed bench for tmax_pattern_checker: single-pattern vector table plus
// multi-pattern, storage-limit, clear/reset and counter-saturation sequences.
module tb_tmax_pattern_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear, ld_valid, ld_ready, start, stop_on_fail;
  logic [4:0] ld_pi, pi_out;
  logic [1:0] ld_xpct, ld_mask, po_in, fail_bits, po_force;
  logic       busy, done, pass, fail_valid, use_model;
  logic [3:0] fail_pattern;
  logic [15:0] nofails;
  logic [4:0] npatterns;

  logic       clear_s, ld_valid_s, ld_ready_s, start_s, stop_s;
  logic [4:0] ld_pi_s, pi_out_s;
  logic [7:0] ld_xpct_s, ld_mask_s, po_in_s, fail_bits_s;
  logic       busy_s, done_s, pass_s, fail_valid_s;
  logic [3:0] fail_pattern_s;
  logic [1:0] nofails_s;
  logic [4:0] npatterns_s;

  int num_checks = 0;
  int num_fails  = 0;
  int fail_idx[$];
  logic [4:0] pat_pi [16];

  always #5 clk = ~clk;

  // Stand-in DUT: either a forced PO value or PO = low PI bits.
  assign po_in = use_model ? pi_out[1:0] : po_force;

  tmax_pattern_checker dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_pi(ld_pi), .ld_xpct(ld_xpct), .ld_mask(ld_mask), .start(start),
    .stop_on_fail(stop_on_fail), .pi_out(pi_out), .po_in(po_in), .busy(busy),
    .done(done), .pass(pass), .fail_valid(fail_valid), .fail_pattern(fail_pattern),
    .fail_bits(fail_bits), .nofails(nofails), .npatterns(npatterns)
  );

  tmax_pattern_checker #(.NOUTPUTS(8), .CAPTURE_DLY(1), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .clear(clear_s), .ld_valid(ld_valid_s), .ld_ready(ld_ready_s),
    .ld_pi(ld_pi_s), .ld_xpct(ld_xpct_s), .ld_mask(ld_mask_s), .start(start_s),
    .stop_on_fail(stop_s), .pi_out(pi_out_s), .po_in(po_in_s), .busy(busy_s),
    .done(done_s), .pass(pass_s), .fail_valid(fail_valid_s), .fail_pattern(fail_pattern_s),
    .fail_bits(fail_bits_s), .nofails(nofails_s), .npatterns(npatterns_s)
  );

  typedef struct {
    logic [4:0] pi;
    logic [1:0] xpct;
    logic [1:0] mask;
    logic [1:0] po;
    logic       exp_fail;
    logic [1:0] exp_bits;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic doClear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic loadPattern(input logic [4:0] pi, input logic [1:0] x, input logic [1:0] m);
    ld_valid = 1'b1; ld_pi = pi; ld_xpct = x; ld_mask = m;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic runAndWait(output int cycles, output int pulses);
    bit fin;
    fail_idx.delete();
    pulses = 0; cycles = 0; fin = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (fail_valid) begin
        pulses++;
        fail_idx.push_back(int'(fail_pattern));
      end
      if (done) fin = 1;
    end
    checkOutput("run_reaches_done", 32'(fin), 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v, input int n);
    int cycles, pulses;
    doClear();
    stop_on_fail = 1'b0; use_model = 1'b0; po_force = v.po;
    loadPattern(v.pi, v.xpct, v.mask);
    runAndWait(cycles, pulses);
    checkOutput($sformatf("vec%0d_cycles", n), 32'(cycles), 32'd6);
    checkOutput($sformatf("vec%0d_pulses", n), 32'(pulses), v.exp_fail ? 32'd1 : 32'd0);
    checkOutput($sformatf("vec%0d_pass", n), 32'(pass), v.exp_fail ? 32'd0 : 32'd1);
    checkOutput($sformatf("vec%0d_nofails", n), 32'(nofails), v.exp_fail ? 32'd1 : 32'd0);
    checkOutput($sformatf("vec%0d_fail_bits", n), 32'(fail_bits), 32'(v.exp_bits));
    checkOutput($sformatf("vec%0d_pi_out", n), 32'(pi_out), 32'(v.pi));
    @(negedge clk);
    checkOutput($sformatf("vec%0d_pulse_width", n), 32'(fail_valid), 32'd0);
    checkOutput($sformatf("vec%0d_done_held", n), 32'(done), 32'd1);
  endtask

  initial begin
    int cycles, pulses, idx0, idx1;
    rst_n = 1'b0; clear = 0; ld_valid = 0; start = 0; stop_on_fail = 0;
    ld_pi = '0; ld_xpct = '0; ld_mask = '0; po_force = '0; use_model = 0;
    clear_s = 0; ld_valid_s = 0; start_s = 0; stop_s = 0;
    ld_pi_s = '0; ld_xpct_s = '0; ld_mask_s = '0; po_in_s = '0;

    vecs[0] = '{5'b10101, 2'b10, 2'b10, 2'b11, 1'b0, 2'b00};
    vecs[1] = '{5'b10101, 2'b10, 2'b10, 2'b00, 1'b1, 2'b10};
    vecs[2] = '{5'b00000, 2'b11, 2'b00, 2'b00, 1'b0, 2'b00};
    vecs[3] = '{5'b11111, 2'b01, 2'b11, 2'b10, 1'b1, 2'b11};
    vecs[4] = '{5'b01010, 2'b00, 2'b01, 2'b11, 1'b1, 2'b01};
    vecs[5] = '{5'b00111, 2'b11, 2'b11, 2'b11, 1'b0, 2'b00};

    repeat (3) @(negedge clk);
    checkOutput("reset_pi_out", 32'(pi_out), 32'd0);
    checkOutput("reset_flags", {28'd0, busy, done, pass, fail_valid}, 32'd0);
    checkOutput("reset_npatterns", 32'(npatterns), 32'd0);
    checkOutput("reset_nofails", 32'(nofails), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_ld_ready", 32'(ld_ready), 32'd1);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

    // Sixteen patterns, PO model = PI[1:0], expected values corrupted at 3 and 9.
    doClear();
    use_model = 1'b1; stop_on_fail = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pat_pi[i] = 5'(i * 7 + 3);
      loadPattern(pat_pi[i], pat_pi[i][1:0] ^ ((i == 3 || i == 9) ? 2'b01 : 2'b00), 2'b11);
    end
    checkOutput("full_npatterns", 32'(npatterns), 32'd16);
    checkOutput("full_ld_ready", 32'(ld_ready), 32'd0);
    loadPattern(5'h1f, 2'b00, 2'b11);
    checkOutput("overflow_ignored", 32'(npatterns), 32'd16);

    runAndWait(cycles, pulses);
    idx0 = (fail_idx.size() > 0) ? fail_idx[0] : -1;
    idx1 = (fail_idx.size() > 1) ? fail_idx[1] : -1;
    checkOutput("multi_cycles", 32'(cycles), 32'd96);
    checkOutput("multi_pulses", 32'(pulses), 32'd2);
    checkOutput("multi_first_idx", 32'(idx0), 32'd3);
    checkOutput("multi_second_idx", 32'(idx1), 32'd9);
    checkOutput("multi_nofails", 32'(nofails), 32'd2);
    checkOutput("multi_pass", 32'(pass), 32'd0);
    checkOutput("multi_fail_pattern", 32'(fail_pattern), 32'd9);
    checkOutput("multi_fail_bits", 32'(fail_bits), 32'd1);
    checkOutput("multi_pi_out", 32'(pi_out), 32'(pat_pi[15]));

    stop_on_fail = 1'b1;
    runAndWait(cycles, pulses);
    checkOutput("stop_cycles", 32'(cycles), 32'd24);
    checkOutput("stop_pulses", 32'(pulses), 32'd1);
    checkOutput("stop_nofails", 32'(nofails), 32'd1);
    checkOutput("stop_pi_out", 32'(pi_out), 32'(pat_pi[3]));
    checkOutput("stop_busy", 32'(busy), 32'd0);
    stop_on_fail = 1'b0; use_model = 1'b0;

    // Empty storage: start goes straight to DONE with pass.
    doClear();
    runAndWait(cycles, pulses);
    checkOutput("empty_cycles", 32'(cycles), 32'd1);
    checkOutput("empty_pass", 32'(pass), 32'd1);

    // clear while waiting for the capture.
    doClear();
    loadPattern(5'b11001, 2'b00, 2'b11);
    start = 1'b1; @(negedge clk); start = 1'b0;
    @(negedge clk);
    checkOutput("wait_busy", 32'(busy), 32'd1);
    checkOutput("wait_pi_out", 32'(pi_out), 32'b11001);
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    checkOutput("clear_busy", 32'(busy), 32'd0);
    checkOutput("clear_pi_out", 32'(pi_out), 32'd0);
    checkOutput("clear_npatterns", 32'(npatterns), 32'd0);
    checkOutput("clear_done", 32'(done), 32'd0);

    // Asynchronous reset in the middle of MEASURE.
    loadPattern(5'b10110, 2'b11, 2'b11);
    po_force = 2'b00;
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_pi_out", 32'(pi_out), 32'd0);
    checkOutput("async_flags", {28'd0, busy, done, pass, fail_valid}, 32'd0);
    checkOutput("async_npatterns", 32'(npatterns), 32'd0);
    checkOutput("async_nofails", 32'(nofails), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Small configuration: 4 failing patterns saturate a 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      ld_valid_s = 1'b1; ld_pi_s = 5'(i + 1); ld_xpct_s = 8'hff;
      case (i)
        0: ld_mask_s = 8'h01;
        1: ld_mask_s = 8'h02;
        2: ld_mask_s = 8'h80;
        3: ld_mask_s = 8'hff;
        default: ld_mask_s = 8'h00;
      endcase
      @(negedge clk);
    end
    ld_valid_s = 1'b0;
    checkOutput("small_npatterns", 32'(npatterns_s), 32'd5);
    start_s = 1'b1; @(negedge clk); start_s = 1'b0;
    cycles = 0; pulses = 0;
    while (!done_s && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (fail_valid_s) pulses++;
    end
    checkOutput("small_done", 32'(done_s), 32'd1);
    checkOutput("small_cycles", 32'(cycles), 32'd15);
    checkOutput("small_pulses", 32'(pulses), 32'd4);
    checkOutput("small_nofails_sat", 32'(nofails_s), 32'd3);
    checkOutput("small_fail_bits", 32'(fail_bits_s), 32'hff);
    checkOutput("small_fail_pattern", 32'(fail_pattern_s), 32'd3);
    checkOutput("small_pass", 32'(pass_s), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
